bit_correlator: RTL

//   Serial-bit correlator front end. It slides a PATTERN_LEN-bit window over
//   the incoming bit stream and scores each window against PATTERN.
//   It counts threshold matches in a saturating 2-bit counter, match_cnt.

---
 rtl/bit_correlator_if.sv | 22 ++
 rtl/bit_correlator.sv | 110 +++++++++++
 2 files changed

// File: rtl/bit_correlator_if.sv
// Bus bundle for bit_correlator: serial bit input side plus score/match status.
interface bit_correlator_if #(
   parameter int unsigned SW = 4
);
   logic          bit_in;
   logic          bit_valid;
   logic          clear;
   logic [SW-1:0] score;
   logic          match;
   logic [1:0]    match_cnt;
   logic          sat;

   modport master (
      output bit_in, bit_valid, clear,
      input  score, match, match_cnt, sat
   );

   modport slave (
      input  bit_in, bit_valid, clear,
      output score, match, match_cnt, sat
   );
endinterface

// File: rtl/bit_correlator.sv
// Serial-bit correlator: slides a PATTERN_LEN-bit window over the bit stream,
// scores each window against PATTERN and counts threshold matches (saturating at 3).
module bit_correlator #(
   parameter int unsigned            PATTERN_LEN = 8,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 8'b10110010,
   parameter int unsigned            THRESHOLD   = 8
) (
   input logic             clk,
   input logic             rst_n,
   bit_correlator_if.slave bus
);
   localparam int unsigned SW = $clog2(PATTERN_LEN + 1);
   localparam int unsigned FW = $clog2(PATTERN_LEN);

   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_SAT  = 2'd2;

   localparam logic [SW-1:0] LEN_SW    = SW'(PATTERN_LEN);
   localparam logic [SW-1:0] THR_SW    = SW'(THRESHOLD);
   localparam logic [FW-1:0] FILL_LAST = FW'(PATTERN_LEN - 1);

   logic [PATTERN_LEN-1:0] r_win;
   logic [FW-1:0]          r_fill;
   logic [1:0]             r_state;
   logic [SW-1:0]          r_score;
   logic                   r_match;
   logic [1:0]             r_cnt;
   logic                   r_sat;

   logic [PATTERN_LEN-1:0] w_win_nxt;
   logic [PATTERN_LEN-1:0] w_diff;
   logic [SW-1:0]          w_miss;
   logic [SW-1:0]          w_nxt_score;
   logic                   w_score_en;
   logic                   w_hit;
   logic [1:0]             w_state_nxt;

   assign w_win_nxt   = {r_win[PATTERN_LEN-2:0], bus.bit_in};
   assign w_diff      = w_win_nxt ^ PATTERN;
   assign w_nxt_score = LEN_SW - w_miss;
   assign w_hit       = w_score_en && (w_nxt_score >= THR_SW);

   // Count disagreeing bits between the candidate window and the reference.
   always_comb begin
      w_miss = '0;
      for (int unsigned i = 0; i < PATTERN_LEN; i++) begin
         w_miss = w_miss + SW'(w_diff[i]);
      end
   end

   // Score this edge when running, or when the bit completing the first fill arrives.
   always_comb begin
      w_score_en = 1'b0;
      if (bus.bit_valid) begin
         w_score_en = (r_state == ST_RUN) || (r_state == ST_SAT) ||
                      ((r_state == ST_FILL) && (r_fill == FILL_LAST));
      end
   end

   // Next-state logic; clear beats a saturating match, unused encoding falls back to FILL.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL: if (bus.bit_valid && (r_fill == FILL_LAST)) w_state_nxt = ST_RUN;
         ST_RUN:  if (!bus.clear && w_hit && (r_cnt == 2'd2)) w_state_nxt = ST_SAT;
         ST_SAT:  if (bus.clear) w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_FILL;
      endcase
   end

   // Window, fill counter, score/match and saturating match counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_win   <= '0;
         r_fill  <= '0;
         r_state <= ST_FILL;
         r_score <= '0;
         r_match <= 1'b0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_match <= w_hit;
         if (bus.bit_valid) begin
            r_win <= w_win_nxt;
         end
         if ((r_state == ST_FILL) && bus.bit_valid && (r_fill != FILL_LAST)) begin
            r_fill <= r_fill + 1'b1;
         end else if ((r_state != ST_FILL) && (r_state != ST_RUN) && (r_state != ST_SAT)) begin
            r_fill <= '0;
         end
         if (w_score_en) begin
            r_score <= w_nxt_score;
         end
         if (bus.clear) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (w_hit && (r_cnt != 2'd3)) begin
            r_cnt <= r_cnt + 1'b1;
            r_sat <= (r_cnt == 2'd2);
         end
      end
   end

   assign bus.score     = r_score;
   assign bus.match     = r_match;
   assign bus.match_cnt = r_cnt;
   assign bus.sat       = r_sat;
endmodule
